// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered load results onto the single register-file write port.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     wr_en,
  output logic [4:0]               wr_reg,
  output logic [XLEN-1:0]          wr_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]      rd_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]   head_q, tail_q;
  logic [AW:0]     count_q;
  logic            wr_en_q;
  logic [4:0]      wr_reg_q;
  logic [XLEN-1:0] wr_data_q;
  logic alu_hit, ld_ok, pop, head_issue, bypass, push;
  assign ld_ready   = (count_q < (AW+1)'(DEPTH)) && !rst;
  assign alu_hit    = alu_valid && alu_rd != 5'd0;
  assign ld_ok      = ld_valid && ld_ready && ld_rd != 5'd0 && !(alu_hit && ld_rd == alu_rd);
  assign pop        = !alu_hit && count_q != '0;
  assign head_issue = pop && live_q[head_q];
  assign bypass     = !alu_hit && count_q == '0 && ld_ok;
  assign push       = ld_ok && !bypass;
  // Live bits double as occupancy for the mask: a popped slot is always cleared.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++)
      if (alu_hit && rd_q[i] == alu_rd) live_d[i] = 1'b0;
    if (pop) live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = 1'b1;
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) pend_mask[rd_q[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= ld_rd;
      data_q[tail_q] <= ld_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      live_q    <= live_d;
      head_q    <= pop ? head_q + AW'(1) : head_q;
      tail_q    <= push ? tail_q + AW'(1) : tail_q;
      count_q   <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      wr_en_q   <= alu_hit || head_issue || bypass;
      wr_reg_q  <= alu_hit ? alu_rd : head_issue ? rd_q[head_q] : bypass ? ld_rd : wr_reg_q;
      wr_data_q <= alu_hit ? alu_data : head_issue ? data_q[head_q] : bypass ? ld_data : wr_data_q;
    end
  end
  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign fifo_count = count_q;
  a_wr_nz:   assert property (@(posedge clk) disable iff (rst) wr_en_q |-> wr_reg_q != 5'd0);
  a_cnt:     assert property (@(posedge clk) disable iff (rst) count_q <= (AW+1)'(DEPTH));
  a_no_over: assert property (@(posedge clk) disable iff (rst) !(ld_valid && ld_ready && count_q == (AW+1)'(DEPTH)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst;
  logic alu_valid, ld_valid, ld_ready, wr_en;
  logic [4:0] alu_rd, ld_rd, wr_reg;
  logic [31:0] alu_data, ld_data, wr_data, pend_mask;
  logic [2:0] fifo_count;
  int vectors = 0, miss = 0;
  bit chk_en = 0;
  typedef struct {logic [4:0] rd; logic [31:0] data; bit live;} ent_t;
  ent_t mq[$], nq[$];
  logic m_en = 0, n_en;
  logic [4:0] m_reg = 0, n_reg;
  logic [31:0] m_data = 0, n_data;
  regfile_wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pend_mask(pend_mask), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_pend();
    logic [31:0] pm = '0;
    foreach (mq[i]) if (mq[i].live) pm[mq[i].rd] = 1'b1;
    return pm;
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("wr_en", {31'd0, wr_en}, {31'd0, m_en});
    chk("wr_reg", {27'd0, wr_reg}, {27'd0, m_reg});
    chk("wr_data", wr_data, m_data);
    chk("pend_mask", pend_mask, model_pend());
    chk("fifo_count", {29'd0, fifo_count}, mq.size());
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, mq.size() < DEPTH && !rst});
  end
  task automatic model_step();
    bit ah, acc, byp;
    ent_t e;
    nq = mq; n_en = 0; n_reg = m_reg; n_data = m_data; byp = 0;
    ah  = alu_valid && alu_rd != 0;
    acc = ld_valid && nq.size() < DEPTH && !rst;
    if (rst) begin
      nq.delete(); n_reg = 0; n_data = 0;
    end else begin
      if (ah) foreach (nq[i]) if (nq[i].rd == alu_rd) nq[i].live = 0;
      if (ah) begin
        n_en = 1; n_reg = alu_rd; n_data = alu_data;
      end else if (nq.size() > 0) begin
        e = nq.pop_front();
        if (e.live) begin n_en = 1; n_reg = e.rd; n_data = e.data; end
      end else if (acc && ld_rd != 0) begin
        n_en = 1; n_reg = ld_rd; n_data = ld_data; byp = 1;
      end
      if (acc && !byp && ld_rd != 0 && !(ah && ld_rd == alu_rd)) nq.push_back('{ld_rd, ld_data, 1'b1});
    end
  endtask
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldd, input bit r);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; rst = r;
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
    mq = nq; m_en = n_en; m_reg = n_reg; m_data = n_data;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0; rst = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 1);
    chk_en = 1;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    idle();
    step(1, 5, 32'h11, 0, 0, 0, 0);
    chk("s1_en", {31'd0, wr_en}, 1);
    chk("s1_reg", {27'd0, wr_reg}, 5);
    chk("s1_data", wr_data, 32'h11);
    idle();
    chk("s1_off", {31'd0, wr_en}, 0);
    step(1, 1, 32'hA, 1, 2, 32'hB, 0);
    chk("s2_reg", {27'd0, wr_reg}, 1);
    chk("s2_data", wr_data, 32'hA);
    chk("s2_pend", pend_mask, 32'h4);
    idle();
    chk("s2_ld_reg", {27'd0, wr_reg}, 2);
    chk("s2_ld_data", wr_data, 32'hB);
    chk("s2_empty", {29'd0, fifo_count}, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("s3_full_ready", {31'd0, ld_ready}, 0);
      step(1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'(100 + i), 0);
    end
    chk("s3_count", {29'd0, fifo_count}, 4);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("s3_drain_reg", {27'd0, wr_reg}, 20 + i);
      chk("s3_drain_data", wr_data, 100 + i);
    end
    idle();
    chk("s3_done", {31'd0, wr_en}, 0);
    step(1, 3, 32'h33, 1, 7, 32'h77, 0);
    chk("s4_pend", pend_mask, 32'h80);
    step(1, 7, 32'h99, 0, 0, 0, 0);
    chk("s4_cancel", pend_mask, 0);
    chk("s4_data", wr_data, 32'h99);
    idle();
    chk("s4_dead_pop", {31'd0, wr_en}, 0);
    chk("s4_hold", wr_data, 32'h99);
    step(1, 0, 32'hFF, 1, 0, 32'hEE, 0);
    chk("s5_en", {31'd0, wr_en}, 0);
    chk("s5_count", {29'd0, fifo_count}, 0);
    for (int i = 0; i < 3; i++) step(1, 11, 32'h5, 1, 5'(12 + i), 32'h50, 0);
    chk("s6_fill", {29'd0, fifo_count}, 3);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("s6_count", {29'd0, fifo_count}, 0);
    chk("s6_pend", pend_mask, 0);
    chk("s6_en", {31'd0, wr_en}, 0);
    idle();
    chk("s6_after", {31'd0, wr_en}, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 63) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
